// File: rtl/efuse_autoload_seq.sv
// efuse_autoload_seq
// Power-up autoload sequencer between the PMU and efuse_ctrl. A rising edge
// of pmu_load_req starts a load: every NR-bit bank is requested from
// efuse_ctrl in turn and collected into a private 256-bit shadow. The XOR of
// shadow bytes 0..30 must equal byte 31. On a checksum, vld or timeout failure
// the whole image is reloaded up to MAX_RETRY times. A clean image is published
// on trim_data with trim_valid. The PMU is acked on pass or final fail.
//
// Ports
//   clk, rst_n           single clock, asynchronous active-low reset
//   pmu_load_req/ack     PMU level request / load-finished acknowledge
//   efuse_start          one-cycle start pulse to efuse_ctrl
//   efuse_read_sel       bank index presented to efuse_ctrl
//   efuse_busy           efuse_ctrl busy, holds off the start pulse
//   efuse_autoload_done  one-cycle read-complete pulse
//   efuse_autoload_vld   data-good qualifier, sampled with done
//   efuse_rdata          bank readout, sampled with done
//   trim_data            published trim image
//   trim_valid           trim_data is checksum-clean
//   trim_err             last load failed after all retries
//   retry_cnt            retries consumed in the current or last load
module efuse_autoload_seq #(
  parameter int NR        = 64,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 2047
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pmu_load_req,
  output logic                         pmu_load_ack,
  output logic                         efuse_start,
  output logic [$clog2(256/NR)-1:0]    efuse_read_sel,
  input  logic                         efuse_busy,
  input  logic                         efuse_autoload_done,
  input  logic                         efuse_autoload_vld,
  input  logic [NR-1:0]                efuse_rdata,
  output logic [255:0]                 trim_data,
  output logic                         trim_valid,
  output logic                         trim_err,
  output logic [1:0]                   retry_cnt
);

  localparam int NB = 256 / NR;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] LAST_BANK = BW'(NB - 1);
  localparam logic [BW-1:0] ONE_BANK  = BW'(1);
  localparam logic [11:0]   TMO       = 12'(TIMEOUT);
  localparam logic [1:0]    MAX_R     = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  // Byte 31 carries the XOR of bytes 0..30.
  function automatic logic csum_ok(input logic [255:0] img);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 31; i++) begin
      x = x ^ img[i*8 +: 8];
    end
    return (x == img[255:248]);
  endfunction

  state_t          state_r, state_s;
  logic            req_r;
  logic [BW-1:0]   bank_r, bank_s;
  logic [1:0]      retry_r, retry_s;
  logic [11:0]     tmo_r, tmo_s;
  logic [255:0]    shadow_r, shadow_s;
  logic [255:0]    trim_data_r, trim_data_s;
  logic            valid_r, valid_s;
  logic            err_r, err_s;
  logic            ack_r, ack_s;
  logic            start_r, start_s;

  // Next-state and next-output logic of the load sequencer.
  always_comb begin
    state_s     = state_r;
    bank_s      = bank_r;
    retry_s     = retry_r;
    tmo_s       = tmo_r;
    shadow_s    = shadow_r;
    trim_data_s = trim_data_r;
    valid_s     = valid_r;
    err_s       = err_r;
    ack_s       = ack_r;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Only a request edge seen here starts a load; trim_data is kept.
        if (pmu_load_req && !req_r) begin
          state_s = ST_START;
          bank_s  = {BW{1'b0}};
          retry_s = 2'd0;
          valid_s = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (efuse_busy) begin
          state_s = ST_START;
        end else begin
          start_s = 1'b1;
          tmo_s   = 12'd0;
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmo_s = tmo_r + 12'd1;
        // Good data wins over a timeout reached in the same cycle.
        if (efuse_autoload_done && efuse_autoload_vld) begin
          for (int b = 0; b < NB; b++) begin
            if (bank_r == BW'(b)) begin
              shadow_s[b*NR +: NR] = efuse_rdata;
            end else begin
              shadow_s[b*NR +: NR] = shadow_r[b*NR +: NR];
            end
          end
          if (bank_r == LAST_BANK) begin
            state_s = ST_CHECK;
          end else begin
            bank_s  = bank_r + ONE_BANK;
            state_s = ST_START;
          end
        end else if (efuse_autoload_done || (tmo_r == TMO)) begin
          if (retry_r < MAX_R) begin
            retry_s = retry_r + 2'd1;
            bank_s  = {BW{1'b0}};
            state_s = ST_START;
          end else begin
            state_s = ST_FAIL;
            err_s   = 1'b1;
            ack_s   = pmu_load_req;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (csum_ok(shadow_r)) begin
          state_s     = ST_DONE;
          trim_data_s = shadow_r;
          valid_s     = 1'b1;
          // A request already dropped mid-load is never acked.
          ack_s       = pmu_load_req;
        end else if (retry_r < MAX_R) begin
          retry_s = retry_r + 2'd1;
          bank_s  = {BW{1'b0}};
          state_s = ST_START;
        end else begin
          state_s = ST_FAIL;
          err_s   = 1'b1;
          ack_s   = pmu_load_req;
        end
      end
      ST_DONE, ST_FAIL: begin
        if (!pmu_load_req) begin
          state_s = ST_IDLE;
          ack_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      req_r       <= 1'b0;
      bank_r      <= {BW{1'b0}};
      retry_r     <= 2'd0;
      tmo_r       <= 12'd0;
      shadow_r    <= 256'd0;
      trim_data_r <= 256'd0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      ack_r       <= 1'b0;
      start_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_r       <= pmu_load_req;
      bank_r      <= bank_s;
      retry_r     <= retry_s;
      tmo_r       <= tmo_s;
      shadow_r    <= shadow_s;
      trim_data_r <= trim_data_s;
      valid_r     <= valid_s;
      err_r       <= err_s;
      ack_r       <= ack_s;
      start_r     <= start_s;
    end
  end

  assign pmu_load_ack   = ack_r;
  assign efuse_start    = start_r;
  assign efuse_read_sel = bank_r;
  assign trim_data      = trim_data_r;
  assign trim_valid     = valid_r;
  assign trim_err       = err_r;
  assign retry_cnt      = retry_r;

endmodule

// File: tb/tb_efuse_autoload_seq.sv
// tb_efuse_autoload_seq
// Directed bench for efuse_autoload_seq. A behavioural efuse_ctrl responder
// answers each start pulse after a fixed latency. A pass-level model predicts
// the bank order, retries and final image of each load, and a per-cycle
// process compares every start pulse and the published image against it.
module tb_efuse_autoload_seq;

  localparam int NR        = 64;
  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 2047;
  localparam int NB        = 256 / NR;
  localparam int LAT       = 3;

  logic                      clk;
  logic                      rst_n;
  logic                      pmu_load_req;
  logic                      pmu_load_ack;
  logic                      efuse_start;
  logic [$clog2(NB)-1:0]     efuse_read_sel;
  logic                      efuse_busy;
  logic                      efuse_autoload_done;
  logic                      efuse_autoload_vld;
  logic [NR-1:0]             efuse_rdata;
  logic [255:0]              trim_data;
  logic                      trim_valid;
  logic                      trim_err;
  logic [1:0]                retry_cnt;

  efuse_autoload_seq #(.NR(NR), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pmu_load_req        (pmu_load_req),
    .pmu_load_ack        (pmu_load_ack),
    .efuse_start         (efuse_start),
    .efuse_read_sel      (efuse_read_sel),
    .efuse_busy          (efuse_busy),
    .efuse_autoload_done (efuse_autoload_done),
    .efuse_autoload_vld  (efuse_autoload_vld),
    .efuse_rdata         (efuse_rdata),
    .trim_data           (trim_data),
    .trim_valid          (trim_valid),
    .trim_err            (trim_err),
    .retry_cnt           (retry_cnt)
  );

  localparam logic [255:0] CLEAN_IMG =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_times[$];
  int exp_q[$];
  int cur_mode = 0;
  int pass_idx = -1;
  int last_done_cyc = 0;
  int m_retry, m_pulses;
  bit m_valid, m_err;
  logic [255:0] model_trim = 256'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Test image: byte i = i, byte 31 optionally corrupted.
  function automatic logic [255:0] img_for(input int mode, input int pass);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(i);
    if ((mode == 1 && pass == 0) || mode == 2) v[255:248] = v[255:248] ^ 8'hff;
    return v;
  endfunction

  function automatic logic csum_good(input logic [255:0] img);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 31; i++) x = x ^ img[i*8 +: 8];
    return x == img[255:248];
  endfunction

  // Modes: 0 clean, 1 bad checksum first pass, 2 always bad checksum,
  // 3 bank 2 silent on first pass, 4 bank 1 vld=0 on first pass.
  task automatic model_build(input int mode);
    bit ok;
    exp_q.delete();
    m_valid = 1'b0;
    m_err = 1'b0;
    m_retry = 0;
    for (int p = 0; p <= MAX_RETRY; p++) begin
      ok = 1'b1;
      for (int b = 0; b < NB; b++) begin
        exp_q.push_back(b);
        if ((mode == 3 && p == 0 && b == 2) || (mode == 4 && p == 0 && b == 1)) begin
          ok = 1'b0;
          break;
        end
      end
      if (ok) ok = csum_good(img_for(mode, p));
      m_retry = p;
      if (ok) begin
        m_valid = 1'b1;
        model_trim = img_for(mode, p);
        break;
      end else if (p == MAX_RETRY) begin
        m_err = 1'b1;
      end
    end
    m_pulses = exp_q.size();
  endtask

  // Behavioural efuse_ctrl: answers each start pulse LAT cycles later.
  initial begin
    int pend;
    int rb;
    logic [255:0] img;
    pend = 0;
    rb = 0;
    efuse_autoload_done = 1'b0;
    efuse_autoload_vld = 1'b0;
    efuse_rdata = '0;
    forever begin
      @(negedge clk);
      efuse_autoload_done = 1'b0;
      efuse_autoload_vld = 1'b0;
      efuse_rdata = '0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0 && !(cur_mode == 3 && pass_idx == 0 && rb == 2)) begin
            img = img_for(cur_mode, pass_idx);
            efuse_autoload_done = 1'b1;
            efuse_autoload_vld = !(cur_mode == 4 && pass_idx == 0 && rb == 1);
            efuse_rdata = img[rb*NR +: NR];
            last_done_cyc = cyc;
          end
        end
        if (efuse_start === 1'b1) begin
          pend = LAT;
          rb = int'(efuse_read_sel);
          if (rb == 0) pass_idx++;
        end
      end
    end
  end

  // Per-cycle comparison of start pulses and published image against the model.
  always @(negedge clk) begin
    if (rst_n && efuse_start === 1'b1) begin
      pulse_cnt++;
      pulse_times.push_back(cyc);
      if (exp_q.size() == 0) chk("read_sel_unexpected_pulse", efuse_read_sel, 256'hdead);
      else chk("read_sel", efuse_read_sel, exp_q.pop_front());
    end
    if (rst_n && trim_valid === 1'b1) begin
      chk("valid_image_checksum", csum_good(trim_data), 1);
      chk("valid_without_err", trim_err, 0);
    end
  end

  task automatic prep_load(input int mode);
    model_build(mode);
    pulse_cnt = 0;
    pulse_times.delete();
    pass_idx = -1;
    cur_mode = mode;
  endtask

  task automatic run_load(input int mode, input int lit_pulses, input int lit_retry,
                          input int busy_cyc, input int lit_gap);
    int t0, t_ack, exp_delay;
    bit ok;
    prep_load(mode);
    @(negedge clk); #1;
    t0 = cyc;
    pmu_load_req = 1'b1;
    efuse_busy = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      @(negedge clk); #1;
      chk("no_start_while_busy", pulse_cnt, 0);
    end
    efuse_busy = 1'b0;
    ok = 1'b0;
    t_ack = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = pmu_load_ack;
      t_ack = cyc;
    end
    chk("ack_rise", ok, 1);
    chk("pulses_model", pulse_cnt, m_pulses);
    chk("pulses_literal", pulse_cnt, lit_pulses);
    chk("model_queue_drained", exp_q.size(), 0);
    exp_delay = (busy_cyc > 1) ? busy_cyc + 1 : 2;
    if (pulse_times.size() > 0) chk("first_start_delay", pulse_times[0] - t0, exp_delay);
    else chk("first_start_seen", 0, 1);
    chk("ack_latency_after_done", t_ack - last_done_cyc, 2);
    chk("retry_cnt_model", retry_cnt, m_retry);
    chk("retry_cnt_literal", retry_cnt, lit_retry);
    chk("trim_valid", trim_valid, m_valid);
    chk("trim_err", trim_err, m_err);
    chk("trim_data", trim_data, model_trim);
    if (lit_gap > 0) begin
      if (pulse_times.size() >= 4) chk("timeout_restart_gap", pulse_times[3] - pulse_times[2], lit_gap);
      else chk("timeout_restart_seen", pulse_times.size(), 4);
    end
    pmu_load_req = 1'b0;
    @(negedge clk); #1;
    chk("ack_release", pmu_load_ack, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_trim = 256'd0;
  endtask

  task automatic wait_pulses(input int n);
    for (int i = 0; i < 2000 && pulse_cnt < n; i++) begin
      @(negedge clk); #1;
    end
    chk("pulse_wait", pulse_cnt >= n, 1);
  endtask

  initial begin
    bit ok, ack_seen;
    rst_n = 1'b1;
    pmu_load_req = 1'b0;
    efuse_busy = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", pmu_load_ack, 0);
    chk("rst_start", efuse_start, 0);
    chk("rst_sel", efuse_read_sel, 0);
    chk("rst_trim_data", trim_data, 0);
    chk("rst_trim_valid", trim_valid, 0);
    chk("rst_trim_err", trim_err, 0);
    chk("rst_retry", retry_cnt, 0);
    #1 rst_n = 1'b1;

    // Clean load, pinned against the literal image.
    run_load(0, 4, 0, 0, 0);
    chk("clean_image_literal", trim_data, CLEAN_IMG);
    // Checksum fails once, then recovers.
    run_load(1, 8, 1, 0, 0);
    // Bank 2 silent on the first pass: restart after TIMEOUT+1 WAIT cycles.
    run_load(3, 7, 1, 0, TIMEOUT + 2);
    // One done with vld=0.
    run_load(4, 6, 1, 0, 0);
    // Busy held 10 cycles at the request.
    run_load(0, 4, 0, 10, 0);

    // New request clears trim_valid; request dropped mid-load is never acked.
    prep_load(0);
    @(negedge clk); #1;
    pmu_load_req = 1'b1;
    @(negedge clk); #1;
    chk("valid_cleared_on_reload", trim_valid, 0);
    wait_pulses(2);
    pmu_load_req = 1'b0;
    ack_seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); #1;
      ok = trim_valid;
      ack_seen = ack_seen | pmu_load_ack;
    end
    chk("dropped_req_load_completes", ok, 1);
    repeat (5) begin
      @(negedge clk); #1;
      ack_seen = ack_seen | pmu_load_ack;
    end
    chk("no_ack_after_req_dropped", ack_seen, 0);
    chk("dropped_req_pulses", pulse_cnt, 4);
    chk("dropped_req_image", trim_data, CLEAN_IMG);

    // Persistent checksum failure from a fresh reset.
    do_reset();
    chk("trim_zero_after_reset", trim_data, 0);
    run_load(2, 12, 2, 0, 0);

    // Asynchronous reset while waiting for done.
    prep_load(0);
    @(negedge clk); #1;
    pmu_load_req = 1'b1;
    wait_pulses(2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ack", pmu_load_ack, 0);
    chk("arst_start", efuse_start, 0);
    chk("arst_sel", efuse_read_sel, 0);
    chk("arst_trim_data", trim_data, 0);
    chk("arst_trim_valid", trim_valid, 0);
    chk("arst_trim_err", trim_err, 0);
    chk("arst_retry", retry_cnt, 0);
    exp_q.delete();
    pmu_load_req = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("no_start_after_reset", pulse_cnt, 2);
    chk("no_ack_after_reset", pmu_load_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
